// File: rtl/mem_port_arbiter_pkg.sv
// mips_mem_pkg: shared types for the FETCH/MEM unified-RAM port arbiter (state, owner, byte-enable width)
package mips_mem_pkg;
  localparam int BE_W = 4;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} arb_state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: FETCH request, MEM request and RAM request/ack buses; slave = arbiter side, master = core/RAM side
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  import mips_mem_pkg::*;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              mem_stall;
  logic              ram_req;
  logic              ram_we;
  logic [BE_W-1:0]   ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ram_rdata, ram_ack,
    output if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
           ram_req, ram_we, ram_be, ram_addr, ram_wdata
  );
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ram_rdata, ram_ack,
    input  if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
           ram_req, ram_we, ram_be, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_grant.sv
// arb_grant_logic: combinational owner select (if_req, mem_req, wait_cnt or last_grant -> any_req, grant); ARB_ROUND_ROBIN_EN selects round robin
module arb_grant_logic
  import mips_mem_pkg::*;
#(
  parameter int MAX_WAIT = 7
) (
  input  logic       if_req,
  input  logic       mem_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_t     last_grant,
`else
  input  logic [3:0] wait_cnt,
`endif
  output logic       any_req,
  output owner_t     grant
);
  assign any_req = if_req | mem_req;
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    grant = !mem_req ? OWN_IF : !if_req ? OWN_MEM : (last_grant == OWN_IF ? OWN_MEM : OWN_IF);
`else
    grant = !mem_req ? OWN_IF : !if_req ? OWN_MEM : (wait_cnt == 4'(MAX_WAIT) ? OWN_IF : OWN_MEM);
`endif
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between FETCH (read) and MEM (read/write); clock, reset, bus (slave); ARB_ROUND_ROBIN_EN selects round robin
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 7
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  arb_state_t        state_q, state_d;
  logic              ram_req_q, ram_req_d, ram_we_q, ram_we_d;
  logic [BE_W-1:0]   ram_be_q, ram_be_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d, if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic              if_valid_q, if_valid_d, mem_valid_q, mem_valid_d;
  logic              any_req;
  owner_t            grant;
`ifdef ARB_ROUND_ROBIN_EN
  owner_t            last_grant_q, last_grant_d;
`else
  logic [3:0]        wait_cnt_q, wait_cnt_d;
`endif
  arb_grant_logic #(.MAX_WAIT(MAX_WAIT)) u_grant (
    .if_req    (bus.if_req),
    .mem_req   (bus.mem_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant(last_grant_q),
`else
    .wait_cnt  (wait_cnt_q),
`endif
    .any_req   (any_req),
    .grant     (grant)
  );
  always_comb begin
    state_d     = state_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_be_d    = ram_be_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`else
    wait_cnt_d   = wait_cnt_q;
`endif
    if (state_q == IDLE) begin
      if (any_req) begin
        state_d     = grant == OWN_MEM ? BUSY_MEM : BUSY_IF;
        ram_req_d   = 1'b1;
        ram_we_d    = grant == OWN_MEM && bus.mem_we;
        ram_be_d    = grant == OWN_MEM ? bus.mem_be : '1;
        ram_addr_d  = grant == OWN_MEM ? bus.mem_addr : bus.if_addr;
        ram_wdata_d = grant == OWN_MEM ? bus.mem_wdata : ram_wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = grant;
`else
        // a FETCH loss is a MEM grant while FETCH was also asking
        wait_cnt_d   = grant == OWN_IF ? 4'd0 :
                       (bus.if_req && wait_cnt_q != 4'(MAX_WAIT)) ? wait_cnt_q + 4'd1 : wait_cnt_q;
`endif
      end
    end else if (bus.ram_ack) begin
      state_d     = IDLE;
      ram_req_d   = 1'b0;
      ram_we_d    = 1'b0;
      if_valid_d  = state_q == BUSY_IF;
      mem_valid_d = state_q == BUSY_MEM;
      if_rdata_d  = state_q == BUSY_IF ? bus.ram_rdata : if_rdata_q;
      mem_rdata_d = (state_q == BUSY_MEM && !ram_we_q) ? bus.ram_rdata : mem_rdata_q;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= OWN_IF;
`else
      wait_cnt_q   <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_be_q    <= ram_be_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`else
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end
  assign bus.ram_req   = ram_req_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_be    = ram_be_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.if_stall  = bus.if_req && !if_valid_q;
  assign bus.mem_stall = bus.mem_req && !mem_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench with a latency-randomised RAM model and a word-array reference
module tb_mem_port_arbiter;
  import mips_mem_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(7)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  int tests = 0;
  int fails = 0;
  logic [31:0] ram_arr [64];
  logic [31:0] ref_mem [64];
  bit model_en = 1'b1;
  int force_lat = -1;
  bit active = 1'b0;
  int lat = 0;
  always @(negedge clock) begin
    if (model_en) begin
      if (bus.ram_ack) bus.ram_ack = 1'b0;
      else if (bus.ram_req) begin
        if (!active) begin
          active = 1'b1;
          lat = force_lat >= 0 ? force_lat : int'($urandom_range(0, 3));
        end
        if (lat == 0) begin
          if (bus.ram_we)
            for (int b = 0; b < 4; b++)
              if (bus.ram_be[b]) ram_arr[bus.ram_addr[7:2]][8*b +: 8] = bus.ram_wdata[8*b +: 8];
          bus.ram_rdata = ram_arr[bus.ram_addr[7:2]];
          bus.ram_ack = 1'b1;
          active = 1'b0;
        end else lat--;
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.if_req = 1'b0;
    bus.mem_req = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clock); #1;
    tests++;
    if ({bus.ram_req, bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata} !== '0)
      begin fails++; $display("FAIL reset_ram: got %h expected 0", {bus.ram_req, bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata}); end
    tests++;
    if ({bus.if_rdata, bus.mem_rdata, bus.if_valid, bus.mem_valid, bus.if_stall, bus.mem_stall} !== '0)
      begin fails++; $display("FAIL reset_out: got %h expected 0", {bus.if_rdata, bus.mem_rdata, bus.if_valid, bus.mem_valid}); end
    tests++;
    if (dut.state_q !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_if_read();
    force_lat = 0;
    @(negedge clock);
    bus.if_addr = 32'h10;
    bus.if_req = 1'b1;
    @(posedge clock); #1;
    tests++;
    if ({bus.ram_req, bus.ram_we, bus.ram_addr} !== {1'b1, 1'b0, 32'h10})
      begin fails++; $display("FAIL if_ram_addr: got req=%b we=%b addr=%h expected 1 0 00000010", bus.ram_req, bus.ram_we, bus.ram_addr); end
    tests++;
    if (bus.if_stall !== 1'b1) begin fails++; $display("FAIL if_stall: got %b expected 1", bus.if_stall); end
    @(posedge clock); #1;
    tests++;
    if (bus.if_valid !== 1'b1) begin fails++; $display("FAIL if_valid_lat: got %b expected 1", bus.if_valid); end
    tests++;
    if (bus.if_rdata !== ref_mem[4]) begin fails++; $display("FAIL if_rdata: got %h expected %h", bus.if_rdata, ref_mem[4]); end
    tests++;
    if (bus.mem_valid !== 1'b0) begin fails++; $display("FAIL if_memvalid: got %b expected 0", bus.mem_valid); end
    bus.if_req = 1'b0;
    @(posedge clock); #1;
    tests++;
    if ({bus.if_valid, bus.ram_req, bus.mem_valid} !== 3'b000)
      begin fails++; $display("FAIL if_pulse: got %b expected 000", {bus.if_valid, bus.ram_req, bus.mem_valid}); end
    force_lat = -1;
  endtask

  task automatic test_mem_write();
    logic [31:0] old_rd;
    old_rd = bus.mem_rdata;
    force_lat = 3;
    @(negedge clock);
    bus.mem_addr = 32'h40;
    bus.mem_be = 4'b0011;
    bus.mem_wdata = 32'hDEADBEEF;
    bus.mem_we = 1'b1;
    bus.mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      tests++;
      if ({bus.ram_req, bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata, bus.mem_valid} !==
          {1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEADBEEF, 1'b0})
        begin fails++; $display("FAIL mw_hold%0d: got req=%b we=%b be=%b addr=%h wd=%h v=%b expected 1 1 0011 00000040 deadbeef 0",
                                i, bus.ram_req, bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata, bus.mem_valid); end
    end
    @(posedge clock); #1;
    tests++;
    if ({bus.mem_valid, bus.ram_req, bus.if_valid} !== 3'b100)
      begin fails++; $display("FAIL mw_done: got %b expected 100", {bus.mem_valid, bus.ram_req, bus.if_valid}); end
    tests++;
    if (bus.mem_rdata !== old_rd) begin fails++; $display("FAIL mw_rdata: got %h expected %h", bus.mem_rdata, old_rd); end
    ref_mem[16][15:0] = 16'hBEEF;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    @(posedge clock); #1;
    tests++;
    if (bus.mem_valid !== 1'b0) begin fails++; $display("FAIL mw_pulse: got %b expected 0", bus.mem_valid); end
    force_lat = -1;
  endtask

  task automatic run_traffic(input int n_if, input int n_mem, input bit pat, input bit gaps);
    int if_done = 0, mem_done = 0, if_iss = 0, mem_iss = 0, g = 0, cyc = 0;
    logic prev_req = 1'b0;
    logic [68:0] cap;
    logic [31:0] old_mrd;
    owner_t exp_own;
    old_mrd = bus.mem_rdata;
    while ((if_done < n_if || mem_done < n_mem) && cyc < 5000) begin
      @(negedge clock);
      cyc++;
`ifdef ARB_ROUND_ROBIN_EN
      exp_own = (g % 2 == 1) ? OWN_IF : OWN_MEM;
`else
      exp_own = (g % 8 == 7) ? OWN_IF : OWN_MEM;
`endif
      if (bus.ram_req && !prev_req) cap = {bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata};
      else if (bus.ram_req) begin
        tests++;
        if ({bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata} !== cap)
          begin fails++; $display("FAIL ram_stable: got %h expected %h", {bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata}, cap); end
      end
      prev_req = bus.ram_req;
      tests++;
      if ({bus.if_stall, bus.mem_stall} !== {bus.if_req && !bus.if_valid, bus.mem_req && !bus.mem_valid})
        begin fails++; $display("FAIL stall: got %b%b expected %b%b", bus.if_stall, bus.mem_stall,
                                bus.if_req && !bus.if_valid, bus.mem_req && !bus.mem_valid); end
      tests++;
      if (bus.if_valid && bus.mem_valid) begin fails++; $display("FAIL dual_valid: got 11 expected one-hot"); end
      if (bus.if_valid) begin
        tests++;
        if ({cap[68], cap[63:32]} !== {1'b0, bus.if_addr})
          begin fails++; $display("FAIL if_ops: got we=%b addr=%h expected 0 %h", cap[68], cap[63:32], bus.if_addr); end
        tests++;
        if (bus.if_rdata !== ref_mem[bus.if_addr[7:2]])
          begin fails++; $display("FAIL if_data: got %h expected %h", bus.if_rdata, ref_mem[bus.if_addr[7:2]]); end
        if (pat) begin
          tests++;
          if (exp_own !== OWN_IF) begin fails++; $display("FAIL order%0d: got IF expected MEM", g); end
        end
        g++;
        if_done++;
        bus.if_req = 1'b0;
      end
      if (bus.mem_valid) begin
        tests++;
        if (cap[68:32] !== {bus.mem_we, bus.mem_we ? bus.mem_be : cap[67:64], bus.mem_addr} ||
            (bus.mem_we && cap[31:0] !== bus.mem_wdata))
          begin fails++; $display("FAIL mem_ops: got %h expected we=%b be=%b addr=%h wd=%h", cap, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata); end
        tests++;
        if (bus.mem_we) begin
          if (bus.mem_rdata !== old_mrd) begin fails++; $display("FAIL mem_wr_rdata: got %h expected %h", bus.mem_rdata, old_mrd); end
          for (int b = 0; b < 4; b++)
            if (bus.mem_be[b]) ref_mem[bus.mem_addr[7:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
        end else begin
          if (bus.mem_rdata !== ref_mem[bus.mem_addr[7:2]])
            begin fails++; $display("FAIL mem_data: got %h expected %h", bus.mem_rdata, ref_mem[bus.mem_addr[7:2]]); end
          old_mrd = ref_mem[bus.mem_addr[7:2]];
        end
        if (pat) begin
          tests++;
          if (exp_own !== OWN_MEM) begin fails++; $display("FAIL order%0d: got MEM expected IF", g); end
        end
        g++;
        mem_done++;
        bus.mem_req = 1'b0;
      end
      if (!bus.if_req && if_iss < n_if && (!gaps || $urandom_range(0, 2) != 0)) begin
        bus.if_addr = 32'($urandom_range(0, 63)) << 2;
        bus.if_req = 1'b1;
        if_iss++;
      end
      if (!bus.mem_req && mem_iss < n_mem && (!gaps || $urandom_range(0, 2) != 0)) begin
        bus.mem_addr = 32'($urandom_range(0, 63)) << 2;
        bus.mem_we = 1'($urandom);
        bus.mem_be = 4'($urandom);
        bus.mem_wdata = $urandom;
        bus.mem_req = 1'b1;
        mem_iss++;
      end
    end
    tests++;
    if (cyc >= 5000) begin fails++; $display("FAIL traffic_timeout: got %0d/%0d done expected %0d/%0d", if_done, mem_done, n_if, n_mem); end
  endtask

  task automatic test_priority();
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    run_traffic(12, 12, 1'b1, 1'b0);
`else
    run_traffic(3, 21, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_random();
    run_traffic(30, 30, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    model_en = 1'b0;
    @(negedge clock);
    bus.ram_ack = 1'b0;
    bus.mem_addr = 32'h24;
    bus.mem_we = 1'b0;
    bus.mem_be = 4'hF;
    bus.mem_req = 1'b1;
    @(posedge clock); #1;
    tests++;
    if (dut.state_q !== BUSY_MEM) begin fails++; $display("FAIL rm_busy: got %0d expected %0d", dut.state_q, BUSY_MEM); end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    tests++;
    if (bus.ram_req !== 1'b0) begin fails++; $display("FAIL rm_req: got %b expected 0", bus.ram_req); end
    @(negedge clock);
    reset = 1'b0;
    bus.mem_req = 1'b0;
    bus.ram_rdata = 32'hA5A5A5A5;
    bus.ram_ack = 1'b1;
    @(posedge clock); #1;
    tests++;
    if ({bus.mem_valid, bus.if_valid, bus.ram_req, bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata, bus.if_rdata, bus.mem_rdata} !== '0)
      begin fails++; $display("FAIL rm_outs: got mv=%b iv=%b req=%b addr=%h mrd=%h expected all 0",
                              bus.mem_valid, bus.if_valid, bus.ram_req, bus.ram_addr, bus.mem_rdata); end
    tests++;
    if (dut.state_q !== IDLE) begin fails++; $display("FAIL rm_state: got %0d expected %0d", dut.state_q, IDLE); end
    @(negedge clock);
    bus.ram_ack = 1'b0;
    model_en = 1'b1;
  endtask

  task automatic test_idle_ack();
    model_en = 1'b0;
    @(negedge clock);
    bus.ram_rdata = 32'h12345678;
    bus.ram_ack = 1'b1;
    @(posedge clock); #1;
    tests++;
    if ({bus.if_valid, bus.mem_valid, bus.ram_req} !== 3'b000)
      begin fails++; $display("FAIL idle_ack_valid: got %b expected 000", {bus.if_valid, bus.mem_valid, bus.ram_req}); end
    tests++;
    if (dut.state_q !== IDLE) begin fails++; $display("FAIL idle_ack_state: got %0d expected %0d", dut.state_q, IDLE); end
    @(negedge clock);
    bus.ram_ack = 1'b0;
    @(posedge clock); #1;
    tests++;
    if ({bus.if_valid, bus.mem_valid} !== 2'b00)
      begin fails++; $display("FAIL idle_ack_late: got %b expected 00", {bus.if_valid, bus.mem_valid}); end
    model_en = 1'b1;
  endtask

  initial begin
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_be = '0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    bus.ram_rdata = '0;
    bus.ram_ack = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ram_arr[i] = $urandom;
      ref_mem[i] = ram_arr[i];
    end
    test_reset();
    test_if_read();
    test_mem_write();
    test_priority();
    test_random();
    test_reset_mid();
    test_idle_ack();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
